// File: rtl/reg_dump_reader.sv
// Walks a combinational register-file read port and streams {address, data}
// words over a valid/ready handshake; full dump of NUMB registers or single read.
module reg_dump_reader #(
    parameter int ADDR = 4,
    parameter int SIZE = 32,
    parameter int NUMB = 1 << ADDR
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic            Single,
    input  logic [ADDR-1:0] Single_Addr,
    output logic [ADDR-1:0] Rd_Addr,
    input  logic [SIZE-1:0] Rd_Data,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [ADDR-1:0] Out_Addr,
    output logic [SIZE-1:0] Out_Data,
    output logic            Busy,
    output logic            Done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_FIN     = 2'd3;

    logic [1:0]      r_state;
    logic [ADDR-1:0] r_rd_addr;
    logic [ADDR-1:0] r_last;
    logic [ADDR-1:0] r_out_addr;
    logic [SIZE-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_single;

    logic            w_accept;
    logic            w_last_word;

    assign w_accept    = r_out_valid && Out_Ready;
    // Single mode always ends after its one word; full dump ends at the last address.
    assign w_last_word = r_single || (r_out_addr == r_last);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_last      <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_single    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_single <= Single;
                        if (Single) begin
                            r_rd_addr <= Single_Addr;
                            r_last    <= Single_Addr;
                        end else begin
                            r_rd_addr <= '0;
                            r_last    <= ADDR'(NUMB - 1);
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Capture here so later register-file writes cannot alter the held word.
                    r_out_data  <= Rd_Data;
                    r_out_addr  <= r_rd_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_last_word) begin
                            r_state <= S_FIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR'(1);
                            r_state   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Rd_Addr   = r_rd_addr;
    assign Out_Addr  = r_out_addr;
    assign Out_Data  = r_out_data;
    assign Out_Valid = r_out_valid;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = (r_state == S_FIN);

endmodule
